sccb_reg_slave: RTL

Synthesizable SCCB responder that models the camera-side end of the SCCB link driven by the CandV_Top master. It decodes 3-phase write and 2-phase read transactions addressed to its device ID and serves them from an internal 8-bit register file. SDA is driven open-drain. A system-side port lets other logic read the registers and observe each committed write. It replaces the behavioural slave in camera-less simulation and serves as a board-level camera stand-in.

---
 rtl/sccb_reg_slave_if.sv | 10 +
 rtl/sccb_reg_slave.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sccb_reg_slave_if.sv
// SCCB pin bundle between a bus master (or pad model) and the register responder.
// The master side owns both pin levels; the slave only reports its open-drain pull-down.
interface sccb_reg_slave_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/sccb_reg_slave.sv
// SCCB camera-side responder: 3-phase write / 2-phase read into an 8-bit register file.
//   state     | meaning
//   IDLE      | bus free, waiting for start
//   ID        | shifting in device ID + R/W bit
//   ID_ACK    | driving ACK for our ID
//   SUB       | shifting in subaddress
//   SUB_ACK   | driving ACK for subaddress
//   WDATA     | shifting in write data
//   WDATA_ACK | driving ACK for write data
//   RDATA     | driving read data, MSB first
//   RNACK     | master's NA bit, ignored
//   IGNORE    | not addressed or transfer over; wait for start/stop
module sccb_reg_slave #(
    parameter logic [6:0] DEV_ID = 7'h21,
    parameter int         ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    sccb_reg_slave_if.slave   sccb,
    output logic              wr_valid,
    output logic [7:0]        wr_addr,
    output logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] sys_addr,
    output logic [7:0]        sys_rdata,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RNACK, IGNORE
    } state_t;

    state_t      state;
    logic        scl_s1, scl_s2, scl_prev;
    logic        sda_s1, sda_s2, sda_prev;
    logic [7:0]  shift;
    logic [7:0]  sub_latched;
    logic [2:0]  bit_cnt;
    logic        byte_full;
    logic        rw;
    logic        sda_oe_q;
    logic [7:0]  regfile [DEPTH];

    logic        scl_rise, scl_fall, sda_rise, sda_fall;
    logic        start_det, stop_det;
    logic        in_range;
    logic [7:0]  rd_byte;

    // Synchronizers reset to 1 so a released bus does not look like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_prev <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_s1   <= sccb.scl_in;
            scl_s2   <= scl_s1;
            scl_prev <= scl_s2;
            sda_s1   <= sccb.sda_in;
            sda_s2   <= sda_s1;
            sda_prev <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_prev;
    assign scl_fall  = ~scl_s2 & scl_prev;
    assign sda_rise  = sda_s2 & ~sda_prev;
    assign sda_fall  = ~sda_s2 & sda_prev;
    assign start_det = sda_fall & scl_s2;
    assign stop_det  = sda_rise & scl_s2;

    assign in_range  = (sub_latched >> ADDR_W) == 8'd0;
    assign rd_byte   = in_range ? regfile[sub_latched[ADDR_W-1:0]] : 8'h00;
    assign sys_rdata = regfile[sys_addr];
    assign sccb.sda_oe = sda_oe_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= 8'h00;
            sub_latched <= 8'h00;
            bit_cnt     <= 3'd0;
            byte_full   <= 1'b0;
            rw          <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy        <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= 8'h00;
            regfile     <= '{default: 8'h00};
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                state     <= ID;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                sda_oe_q  <= 1'b0;
                busy      <= 1'b1;
            end else if (stop_det) begin
                state     <= IDLE;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                sda_oe_q  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                // byte_full marks the 8th rise so the fall right after start is not mistaken for it
                if (scl_rise && (state == ID || state == SUB || state == WDATA || state == RDATA)) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) byte_full <= 1'b1;
                    if (state != RDATA) shift <= {shift[6:0], sda_s2};
                end
                case (state)
                    ID: if (scl_fall && byte_full) begin
                        byte_full <= 1'b0;
                        rw        <= shift[0];
                        if (shift[7:1] == DEV_ID) begin
                            state    <= ID_ACK;
                            sda_oe_q <= 1'b1;
                        end else begin
                            state    <= IGNORE;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    ID_ACK: if (scl_fall) begin
                        bit_cnt <= 3'd0;
                        if (rw) begin
                            state    <= RDATA;
                            shift    <= rd_byte;
                            sda_oe_q <= ~rd_byte[7];
                        end else begin
                            state    <= SUB;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    SUB: if (scl_fall && byte_full) begin
                        byte_full   <= 1'b0;
                        sub_latched <= shift;
                        state       <= SUB_ACK;
                        sda_oe_q    <= 1'b1;
                    end
                    SUB_ACK: if (scl_fall) begin
                        state    <= WDATA;
                        sda_oe_q <= 1'b0;
                    end
                    WDATA: if (scl_fall && byte_full) begin
                        byte_full <= 1'b0;
                        state     <= WDATA_ACK;
                        sda_oe_q  <= 1'b1;
                        if (in_range) begin
                            regfile[sub_latched[ADDR_W-1:0]] <= shift;
                            wr_valid <= 1'b1;
                            wr_addr  <= sub_latched;
                            wr_data  <= shift;
                        end
                    end
                    WDATA_ACK: if (scl_fall) begin
                        state    <= IGNORE;
                        sda_oe_q <= 1'b0;
                    end
                    RDATA: if (scl_fall) begin
                        if (byte_full) begin
                            byte_full <= 1'b0;
                            state     <= RNACK;
                            sda_oe_q  <= 1'b0;
                        end else begin
                            shift    <= {shift[6:0], 1'b0};
                            sda_oe_q <= ~shift[6];
                        end
                    end
                    RNACK:  if (scl_rise) state <= IGNORE;
                    IGNORE: sda_oe_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule
